// File: rtl/epsc_sched_pkg.sv
// Shared constants and state encoding for the EPSC scheduler.
// Counter width is derived from the EPSC latency so a single cnt register covers EPSC_LAT-1..0.
package epsc_sched_pkg;

  localparam int INTEGER_WIDTH_DEF     = 32;
  localparam int DATA_WIDTH_FRAC_DEF   = 32;
  localparam int DELTAT_WIDTH_DEF      = 4;
  localparam int NEURON_ADDR_WIDTH_DEF = 10;
  localparam int EPSC_LAT_DEF          = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;

  function automatic int lat_cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  localparam int LAT_CNT_W_DEF = lat_cnt_width(EPSC_LAT_DEF);

endpackage

// File: rtl/epsc_scheduler.sv
// Walks all neurons of a core through one shared combinational EPSC unit, holding its
// operands stable for EPSC_LAT cycles and streaming {addr, EPSC} over valid/ready.
//
// state      | meaning
// IDLE       | waiting for start; config latched on an accepted start
// FETCH      | one-cycle read strobe for neuron idx
// LOAD       | capture Vmem/gex into operand registers; gex==0 bypasses the unit
// COMPUTE    | operands held; cnt counts down to sample the unit output
// WRITE      | result offered downstream until accepted
module epsc_scheduler
  import epsc_sched_pkg::*;
#(
  parameter int INTEGER_WIDTH     = INTEGER_WIDTH_DEF,
  parameter int DATA_WIDTH_FRAC   = DATA_WIDTH_FRAC_DEF,
  parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int DELTAT_WIDTH      = DELTAT_WIDTH_DEF,
  parameter int NEURON_ADDR_WIDTH = NEURON_ADDR_WIDTH_DEF,
  parameter int EPSC_LAT          = EPSC_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NEURON_ADDR_WIDTH:0]   neuron_count,
  input  logic [INTEGER_WIDTH-1:0]     eex,
  input  logic [DELTAT_WIDTH-1:0]      delta_t,
  input  logic [INTEGER_WIDTH-1:0]     taumem,
  output logic                         rd_en,
  output logic [NEURON_ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]        rd_vmem,
  input  logic [DATA_WIDTH-1:0]        rd_gex,
  output logic [INTEGER_WIDTH-1:0]     unit_eex,
  output logic [DELTAT_WIDTH-1:0]      unit_delta_t,
  output logic [INTEGER_WIDTH-1:0]     unit_taumem,
  output logic [DATA_WIDTH-1:0]        unit_vmem,
  output logic [DATA_WIDTH-1:0]        unit_gex,
  input  logic [DATA_WIDTH-1:0]        unit_epsc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURON_ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]        out_epsc,
  output logic                         busy,
  output logic                         done,
  output logic                         config_error
);

  localparam int CNT_W = lat_cnt_width(EPSC_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EPSC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [NEURON_ADDR_WIDTH:0] COUNT_MAX = {1'b1, {NEURON_ADDR_WIDTH{1'b0}}};
  localparam logic [NEURON_ADDR_WIDTH:0] COUNT_ONE = {{NEURON_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [NEURON_ADDR_WIDTH-1:0] IDX_ONE = {{(NEURON_ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]                   state;
  logic [NEURON_ADDR_WIDTH-1:0] idx;
  logic [NEURON_ADDR_WIDTH-1:0] last_idx;
  logic [CNT_W-1:0]             cnt;
  logic [NEURON_ADDR_WIDTH:0]   count_clamped;
  logic [NEURON_ADDR_WIDTH:0]   count_m1;

  // Oversized counts are clamped so idx can never wrap past the last neuron.
  always_comb begin
    count_clamped = (neuron_count > COUNT_MAX) ? COUNT_MAX : neuron_count;
    count_m1      = count_clamped - COUNT_ONE;
  end

  assign rd_en     = (state == ST_FETCH);
  assign rd_addr   = idx;
  assign out_valid = (state == ST_WRITE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      last_idx     <= '0;
      cnt          <= '0;
      unit_eex     <= '0;
      unit_delta_t <= '0;
      unit_taumem  <= '0;
      unit_vmem    <= '0;
      unit_gex     <= '0;
      out_addr     <= '0;
      out_epsc     <= '0;
      done         <= 1'b0;
      config_error <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            unit_eex     <= eex;
            unit_delta_t <= delta_t;
            unit_taumem  <= taumem;
            idx          <= '0;
            last_idx     <= count_m1[NEURON_ADDR_WIDTH-1:0];
            config_error <= (taumem == '0);
            if (taumem == '0 || count_clamped == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          unit_vmem <= rd_vmem;
          unit_gex  <= rd_gex;
          out_addr  <= idx;
          if (rd_gex == '0) begin
            out_epsc <= '0;
            state    <= ST_WRITE;
          end else begin
            cnt   <= CNT_LOAD;
            state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (cnt == '0) begin
            out_epsc <= unit_epsc;
            out_addr <= idx;
            state    <= ST_WRITE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_WRITE: begin
          if (out_ready) begin
            if (idx == last_idx) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              idx   <= idx + IDX_ONE;
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epsc_scheduler.sv
// Bench for epsc_scheduler: table of passes scored against a cycle-timed result queue,
// plus hand-written stall and mid-pass reset sequences.
module tb_epsc_scheduler;
  import epsc_sched_pkg::*;

  localparam int IW  = 32;
  localparam int DW  = 64;
  localparam int TW  = 4;
  localparam int AW  = 10;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   neuron_count = '0;
  logic [IW-1:0] eex = '0;
  logic [TW-1:0] delta_t = '0;
  logic [IW-1:0] taumem = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_vmem = '0;
  logic [DW-1:0] rd_gex = '0;
  logic [IW-1:0] unit_eex;
  logic [TW-1:0] unit_delta_t;
  logic [IW-1:0] unit_taumem;
  logic [DW-1:0] unit_vmem;
  logic [DW-1:0] unit_gex;
  logic [DW-1:0] unit_epsc;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_epsc;
  logic          busy;
  logic          done;
  logic          config_error;

  always #5 clk = ~clk;

  epsc_scheduler #(
    .INTEGER_WIDTH(IW), .DATA_WIDTH_FRAC(32), .DATA_WIDTH(DW),
    .DELTAT_WIDTH(TW), .NEURON_ADDR_WIDTH(AW), .EPSC_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .neuron_count(neuron_count),
    .eex(eex), .delta_t(delta_t), .taumem(taumem),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_vmem(rd_vmem), .rd_gex(rd_gex),
    .unit_eex(unit_eex), .unit_delta_t(unit_delta_t), .unit_taumem(unit_taumem),
    .unit_vmem(unit_vmem), .unit_gex(unit_gex), .unit_epsc(unit_epsc),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_epsc(out_epsc),
    .busy(busy), .done(done), .config_error(config_error)
  );

  // Stand-in for the shared EPSC unit: any bit-mixing function of all operands will do.
  function automatic logic [DW-1:0] epsc_fn(input logic [DW-1:0] v, input logic [DW-1:0] g,
                                            input logic [IW-1:0] e, input logic [TW-1:0] dt,
                                            input logic [IW-1:0] t);
    return (v ^ {e, t}) + (g << dt) + {{(DW-TW){1'b0}}, dt};
  endfunction

  assign unit_epsc = epsc_fn(unit_vmem, unit_gex, unit_eex, unit_delta_t, unit_taumem);

  logic [DW-1:0] mem_vmem [16];
  logic [DW-1:0] mem_gex  [16];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_vmem <= mem_vmem[rd_addr[3:0]];
      rd_gex  <= mem_gex[rd_addr[3:0]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] epsc;
    logic [DW-1:0] vmem;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  logic [AW-1:0] rd_q[$];
  logic [IW-1:0] x_eex, x_tau;
  logic [TW-1:0] x_dt;
  bit mon_en = 0;
  int base = 0;
  int reads = 0;
  int dones = 0;
  int done_rel = -1;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int rel;
    if (mon_en) begin
      rel = cyc - base;
      if (rd_en) begin
        reads++;
        rd_q.push_back(rd_addr);
      end
      if (done) begin
        dones++;
        done_rel = rel;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got addr %0d expected none", out_addr);
        end else begin
          e = sb.pop_front();
          check("out_addr", 64'(out_addr), 64'(e.addr));
          check("out_epsc", out_epsc, e.epsc);
          if (e.cyc >= 0) check("out_cycle", 64'(rel), 64'(e.cyc));
          check("unit_vmem", unit_vmem, e.vmem);
          check("unit_eex", 64'(unit_eex), 64'(x_eex));
          check("unit_taumem", 64'(unit_taumem), 64'(x_tau));
          check("unit_delta_t", 64'(unit_delta_t), 64'(x_dt));
        end
      end
    end
  end

  typedef struct {
    int            count;
    logic [IW-1:0] eex;
    logic [TW-1:0] dt;
    logic [IW-1:0] tau;
    logic [7:0]    zmask;
    bit            allz;
    bit            golden;
    bit            restart;
    int            exp_done;
    int            exp_reads;
    logic          exp_cerr;
  } vec_t;

  vec_t vecs[8];

  task automatic fill_mem(input logic [7:0] zmask, input bit allz, input bit golden);
    for (int i = 0; i < 16; i++) begin
      mem_vmem[i] = {$urandom, $urandom};
      mem_gex[i]  = {$urandom, $urandom | 32'd1};
      if (allz || (i < 8 && zmask[i])) mem_gex[i] = '0;
    end
    if (golden) begin
      mem_vmem[0] = 64'hFFFF_FFBA_0000_0000;
      mem_gex[0]  = 64'h0000_0001_0000_0000;
    end
  endtask

  // Expected results carry the cycle (relative to start) at which each transfer must occur.
  task automatic push_expected(input int count, input logic [IW-1:0] tau, input bit timed);
    int n;
    int t;
    exp_t e;
    n = (count > (1 << AW)) ? (1 << AW) : count;
    t = 0;
    if (tau == '0) n = 0;
    for (int i = 0; i < n; i++) begin
      e.addr = AW'(i);
      e.vmem = mem_vmem[i % 16];
      if (mem_gex[i % 16] == '0) begin
        e.epsc = '0;
        t += 3;
      end else begin
        e.epsc = epsc_fn(mem_vmem[i % 16], mem_gex[i % 16], x_eex, x_dt, tau);
        t += LAT + 3;
      end
      e.cyc = timed ? t : -1;
      sb.push_back(e);
    end
  endtask

  task automatic begin_pass(input int count, input logic [IW-1:0] e_in, input logic [TW-1:0] dt_in,
                            input logic [IW-1:0] tau, input bit timed);
    @(posedge clk); #1;
    neuron_count = (AW+1)'(count);
    eex = e_in; delta_t = dt_in; taumem = tau;
    start = 1'b1;
    x_eex = e_in; x_dt = dt_in; x_tau = tau;
    base = cyc; reads = 0; dones = 0; done_rel = -1;
    rd_q.delete();
    sb.delete();
    push_expected(count, tau, timed);
    mon_en = 1;
    @(posedge clk); #1;
    start = 1'b0;
    eex = $urandom; taumem = $urandom; delta_t = TW'($urandom); neuron_count = (AW+1)'($urandom);
  endtask

  task automatic finish_pass(input int bound, input int exp_done, input int exp_reads, input logic exp_cerr);
    int bad;
    for (int k = 0; k < bound && dones == 0; k++) @(posedge clk);
    repeat (3) @(negedge clk);
    check("done_count", 64'(dones), 64'd1);
    if (exp_done >= 0) check("done_cycle", 64'(done_rel), 64'(exp_done));
    check("read_count", 64'(reads), 64'(exp_reads));
    bad = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != AW'(i)) bad++;
    check("rd_addr_seq_errors", 64'(bad), 64'd0);
    check("results_left", 64'(sb.size()), 64'd0);
    check("config_error", 64'(config_error), 64'(exp_cerr));
    check("busy_after", 64'(busy), 64'd0);
    mon_en = 0;
  endtask

  initial begin
    int bad;
    vecs[0] = '{3,    32'h0000_1234, 4'd2, 32'd10, 8'h00, 1'b0, 1'b0, 1'b0, 22,   3,    1'b0};
    vecs[1] = '{1,    32'h0000_0000, 4'd1, 32'd10, 8'h00, 1'b0, 1'b1, 1'b0, 8,    1,    1'b0};
    vecs[2] = '{3,    32'hDEAD_0001, 4'd3, 32'd10, 8'h02, 1'b0, 1'b0, 1'b0, 18,   3,    1'b0};
    vecs[3] = '{0,    32'h0000_0005, 4'd1, 32'd10, 8'h00, 1'b0, 1'b0, 1'b0, 1,    0,    1'b0};
    vecs[4] = '{2,    32'h0000_0005, 4'd1, 32'd0,  8'h00, 1'b0, 1'b0, 1'b0, 1,    0,    1'b1};
    vecs[5] = '{1,    32'hFFFF_0000, 4'd7, 32'd5,  8'h00, 1'b0, 1'b0, 1'b1, 8,    1,    1'b0};
    vecs[6] = '{2,    32'h1111_2222, 4'd0, 32'd7,  8'h03, 1'b0, 1'b0, 1'b0, 7,    2,    1'b0};
    vecs[7] = '{1029, 32'h0000_0042, 4'd2, 32'd3,  8'h00, 1'b1, 1'b0, 1'b0, 3073, 1024, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_config_error", 64'(config_error), 64'd0);
    check("rst_unit_vmem", unit_vmem, 64'd0);
    check("rst_out_epsc", out_epsc, 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      fill_mem(vecs[v].zmask, vecs[v].allz, vecs[v].golden);
      begin_pass(vecs[v].count, vecs[v].eex, vecs[v].dt, vecs[v].tau, 1'b1);
      if (vecs[v].restart) begin
        start = 1'b1; neuron_count = (AW+1)'(5); eex = ~vecs[v].eex; taumem = 32'd99;
        @(posedge clk); #1;
        start = 1'b0;
      end
      finish_pass(vecs[v].exp_done + 50, vecs[v].exp_done, vecs[v].exp_reads, vecs[v].exp_cerr);
    end

    // Downstream stall: ready held low for five WRITE cycles of neuron 0.
    fill_mem(8'h00, 1'b0, 1'b0);
    out_ready = 1'b0;
    begin_pass(2, 32'h0BAD_F00D, 4'd5, 32'd9, 1'b0);
    for (int k = 0; k < 30 && !out_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_addr", 64'(out_addr), 64'd0);
      check("stall_out_epsc", out_epsc, epsc_fn(mem_vmem[0], mem_gex[0], 32'h0BAD_F00D, 4'd5, 32'd9));
      check("stall_reads", 64'(reads), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    finish_pass(60, -1, 2, 1'b0);

    // Reset in the middle of COMPUTE, then a clean pass.
    fill_mem(8'h00, 1'b0, 1'b0);
    begin_pass(3, 32'h7777_7777, 4'd4, 32'd4, 1'b0);
    sb.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rd_en", 64'(rd_en), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_unit_eex", 64'(unit_eex), 64'd0);
    check("arst_unit_taumem", 64'(unit_taumem), 64'd0);
    check("arst_unit_gex", unit_gex, 64'd0);
    check("arst_out_epsc", out_epsc, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    reads = 0;
    repeat (12) @(posedge clk);
    #1;
    check("post_reset_done", 64'(dones), 64'd0);
    check("post_reset_reads", 64'(reads), 64'd0);
    check("post_reset_out_valid", 64'(out_valid), 64'd0);
    mon_en = 0;

    fill_mem(8'h00, 1'b0, 1'b0);
    begin_pass(2, 32'h0000_0099, 4'd2, 32'd11, 1'b1);
    finish_pass(80, 15, 2, 1'b0);

    bad = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
